// File: rtl/uart_tx_arb.sv
// Multi-channel UART transmit front end: round-robin arbitration of N_CH
// ready/valid sources into a small FIFO drained by a parametrised serializer.
module uart_tx_arb #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int N_CH       = 2,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_CH*DATA_WIDTH-1:0]       data_in,
   input  logic [N_CH-1:0]                  data_in_valid,
   output logic [N_CH-1:0]                  data_in_ready,
   output logic                             serial_out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             busy
);
   localparam int SET = CLOCK_FREQ / BAUD_RATE;
   localparam int TW  = (SET > 1) ? $clog2(SET) : 1;
   localparam int PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int BW  = 4;

   localparam logic [TW-1:0] T_LAST   = TW'(SET - 1);
   localparam logic [PW:0]   NCH_W    = (PW + 1)'(N_CH);
   localparam logic [BW-1:0] D_LAST   = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] S_LAST   = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic          ODD      = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  serial_q, serial_d;
   logic [PW-1:0]         ptr_q, ptr_d;
   logic [AW-1:0]         wr_q, wr_d;
   logic [AW-1:0]         rd_q, rd_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic [PW-1:0]         gnt;
   logic                  found;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  tick;

   assign full  = (cnt_q == CNT_FULL);
   assign empty = (cnt_q == '0);
   assign tick  = (tmr_q == T_LAST);
   assign rdata = mem[rd_q];

   // Round-robin search beginning at ptr_q; ready is a pure function of valid.
   always_comb begin : arb
      logic [PW:0] cand;
      found = 1'b0;
      gnt   = '0;
      cand  = '0;
      for (int i = 0; i < N_CH; i++) begin
         cand = {1'b0, ptr_q} + (PW + 1)'(i);
         if (cand >= NCH_W) cand = cand - NCH_W;
         if (!found && data_in_valid[cand[PW-1:0]]) begin
            found = 1'b1;
            gnt   = cand[PW-1:0];
         end
      end
      wdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt == PW'(i)) wdata = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      push          = found && !full && !rst;
      data_in_ready = '0;
      if (push) data_in_ready[gnt] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      wr_d  = wr_q;
      if (push) begin
         ptr_d = (gnt == PW'(N_CH - 1)) ? '0 : gnt + PW'(1);
         wr_d  = wr_q + AW'(1);
      end
   end

   // Serializer next state; a pop reloads the shifter and restarts the frame.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      if (state_q != S_IDLE) tmr_d = tick ? '0 : tmr_q + TW'(1);
      unique case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            pop   = !empty;
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == D_LAST) begin
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (bit_q == S_LAST) begin
                  if (empty) state_d = S_IDLE;
                  else       pop     = 1'b1;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         state_d = S_START;
         tmr_d   = '0;
         bit_d   = '0;
         shift_d = rdata;
         par_d   = (^rdata) ^ ODD;
      end
   end

   always_comb begin
      rd_d  = pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      unique case (state_d)
         S_START: serial_d = 1'b0;
         S_DATA:  serial_d = shift_d[0];
         S_PAR:   serial_d = par_d;
         default: serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         bit_q    <= '0;
         serial_q <= 1'b1;
         ptr_q    <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         bit_q    <= bit_d;
         serial_q <= serial_d;
         ptr_q    <= ptr_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
      end
   end

   // Datapath storage carries no reset; contents are only trusted via the pointers.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      par_q   <= par_d;
      if (push) mem[wr_q] <= wdata;
   end

   assign serial_out = serial_q;
   assign fifo_count = cnt_q;
   assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Multi-channel UART transmit front end: N ready/valid byte sources are arbitrated round-robin into a small FIFO, which a parametrised serializer drains onto one serial line. It replaces the hand-built per-source switch mux in front of `uart_transmitter` on z1top boards. Sources such as the button character generator and `read_rom` can all stream concurrently without losing characters.

## Interface
Parameters:
- CLOCK_FREQ, 125_000_000, clock frequency in Hz
- BAUD_RATE, 115_200, line rate; SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division), minimum 2
- N_CH, 2, number of input channels, 1..8
- DATA_WIDTH, 8, data bits per frame, 5..9
- FIFO_DEPTH, 8, FIFO entries, power of two, at least 2
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2

Ports:
- clk, input, 1, single clock; all state on rising edge
- rst, input, 1, synchronous, active-high reset
- data_in, input, N_CH*DATA_WIDTH, channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- data_in_valid, input, N_CH, per-channel valid
- data_in_ready, output, N_CH, per-channel ready; at most one bit high per cycle
- serial_out, output, 1, registered TX line, idle high
- fifo_count, output, $clog2(FIFO_DEPTH+1), current FIFO occupancy
- busy, output, 1, high while a frame is on the line or fifo_count is nonzero

## Operation
- Arbiter: round-robin over channels with valid high. Search starts at pointer p (reset 0).
- Arbiter grant and ready: data_in_ready[g] = 1 for the granted channel g only when FIFO not full and rst low. After a transfer, p = (g+1) mod N_CH. p does not change when nothing transfers.
- Ready depends combinationally on valid. Sources must not make valid depend on ready.
- A source holds data and valid stable until its transfer. A source may deassert valid without transferring.
- FIFO write: occurs on the transfer (valid & ready) for the granted channel.
- FIFO full: blocks writes even if a pop occurs in the same cycle.
- FIFO empty: a pop is impossible; no first-word fall-through to the line.
- Simultaneous push and pop when neither full nor empty: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Serializer states: IDLE, START, DATA, PAR, STOP.
  - IDLE: serial_out = 1. If FIFO is non-empty, pop into the shift register and go to START.
  - START: line 0 for SYMBOL_EDGE_TIME cycles.
  - DATA: DATA_WIDTH bits, LSB first, each SYMBOL_EDGE_TIME cycles.
  - PAR: present only if PARITY != 0. Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: line 1 for STOP_BITS × SYMBOL_EDGE_TIME cycles.
- End of STOP: if FIFO is non-empty, pop and go directly to START. Consecutive frames have no idle gap. Otherwise go to IDLE.
- Bit timer: counts 0..SYMBOL_EDGE_TIME-1; the bit advances on the terminal count.
- Frame length: (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) × SYMBOL_EDGE_TIME cycles.

## Timing
- Reset values: serial_out = 1, data_in_ready = 0, fifo_count = 0, busy = 0. Also state = IDLE, p = 0, FIFO pointers = 0.
- Reset during rst: data_in_ready is held 0 while rst is high.
- Reset mid-frame: serial_out returns to 1 the cycle after the rst edge. FIFO contents are discarded and no partial frame resumes.
- Latency, idle block: transfer in cycle t. fifo_count = 1 in t+1, and the pop occurs in t+1. serial_out goes low from t+2. fifo_count returns to 0 in t+2.
- Throughput in: one word per cycle while not full.
- Throughput out: one frame per frame length.
- busy: drops in the cycle after the last stop-bit cycle if the FIFO is empty.

## Test plan
Simulation settings: CLOCK_FREQ=1000, BAUD_RATE=100, so 10 cycles per bit.

- Single byte, defaults: ch0 sends 8'h41. serial_out low at t+2. Line carries bits 1,0,0,0,0,0,1,0, then stop 1. Frame is 100 cycles; busy then drops.
- Fairness, N_CH=3: all channels hold valid with 8'h61/8'h62/8'h63. Grants go 0,1,2,0,1,2. FIFO order matches the grants.
- Full FIFO, FIFO_DEPTH=4: 6 words offered back-to-back. Ready is low once fifo_count = 4. The remaining words are accepted one per frame. All 6 are serialized in order with no inter-frame idle.
- Parity and stops: PARITY=2, STOP_BITS=2, DATA_WIDTH=7, byte 7'h55. Parity bit = 1. Stop high for 20 cycles. Total frame 110 cycles.
- Reset mid-frame: assert rst 35 cycles into a frame with 3 words queued. serial_out = 1 and fifo_count = 0 the next cycle. No further start bit appears until new data arrives.
- Pop/push overlap: FIFO at count 2, simultaneous push and pop. Count stays 2 and data order is preserved across the pointer wrap.
